// File: rtl/scan_sequencer_pkg.sv
// rtl/scan_sequencer_pkg.sv - shared scan sequencer widths and dwell defaults
package scan_sequencer_pkg;

  localparam int DEFAULT_CODE_W = 1;
  localparam int DEFAULT_DWELL  = 4;

  // Dwell counter needs at least one bit even when DWELL is 1.
  function automatic int dcnt_width(input int dwell);
    return (dwell > 2) ? $clog2(dwell) : 1;
  endfunction

  localparam int DEFAULT_DCNT_W = dcnt_width(DEFAULT_DWELL);

endpackage

// File: rtl/scan_sequencer_dwell_prescaler.sv
// rtl/scan_sequencer_dwell_prescaler.sv - dwell counter with terminal-count flag
module dwell_prescaler
  import scan_sequencer_pkg::*;
#(
  parameter int DWELL = DEFAULT_DWELL,
  parameter int CNT_W = dcnt_width(DWELL)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] dcnt;

  assign tc = (dcnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dcnt <= '0;
    end else if (clear) begin
      dcnt <= '0;
    end else if (enable) begin
      dcnt <= tc ? '0 : dcnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - registered select-code stepper feeding the one-hot decoders
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int CODE_W = DEFAULT_CODE_W,
  parameter int DWELL  = DEFAULT_DWELL
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [CODE_W-1:0] load_code,
  output logic [CODE_W-1:0] code,
  output logic              tick,
  output logic              wrap
);

  logic tc;

  dwell_prescaler #(
    .DWELL (DWELL),
    .CNT_W (dcnt_width(DWELL))
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (load),
    .enable (enable),
    .tc     (tc)
  );

  // Load outranks the terminal count, so a coincident load never reports wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      code <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (load) begin
      code <= load_code;
      tick <= 1'b1;
      wrap <= 1'b0;
    end else if (enable && tc) begin
      code <= code + CODE_W'(1);
      tick <= 1'b1;
      wrap <= &code;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - vector, corner-case and randomized checks of scan_sequencer
module tb_scan_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [1:0] load_code = 2'd0;

  logic [1:0] code_a, code_b;
  logic [0:0] code_c, code_d;
  logic       tick_a, tick_b, tick_c, tick_d;
  logic       wrap_a, wrap_b, wrap_c, wrap_d;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  scan_sequencer #(.CODE_W(2), .DWELL(4)) u_a (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .load_code(load_code), .code(code_a), .tick(tick_a), .wrap(wrap_a));
  scan_sequencer #(.CODE_W(2), .DWELL(3)) u_b (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .load_code(load_code), .code(code_b), .tick(tick_b), .wrap(wrap_b));
  scan_sequencer #(.CODE_W(1), .DWELL(4)) u_c (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .load_code(load_code[0:0]), .code(code_c), .tick(tick_c), .wrap(wrap_c));
  scan_sequencer #(.CODE_W(1), .DWELL(1)) u_d (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .load_code(load_code[0:0]), .code(code_d), .tick(tick_d), .wrap(wrap_d));

  typedef struct {
    logic       en;
    logic       ld;
    logic [1:0] lc;
    logic [1:0] code;
    logic       tick;
    logic       wrap;
  } vec_t;

  // Reference model: position p counts enabled cycles since the last load/reset.
  int w_of[4];
  int d_of[4];
  int base[4];
  int p[4];
  int et[4];
  int ew[4];

  function automatic int exp_code(input int i);
    return (base[i] + p[i] / d_of[i]) % (1 << w_of[i]);
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic l, input logic [1:0] lc);
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        base[i] = 0; p[i] = 0; et[i] = 0; ew[i] = 0;
      end else if (l) begin
        base[i] = int'(lc) % (1 << w_of[i]); p[i] = 0; et[i] = 1; ew[i] = 0;
      end else if (e) begin
        p[i]++;
        if (p[i] % d_of[i] == 0) begin
          et[i] = 1; ew[i] = (exp_code(i) == 0) ? 1 : 0;
        end else begin
          et[i] = 0; ew[i] = 0;
        end
      end else begin
        et[i] = 0; ew[i] = 0;
      end
    end
  endtask

  function automatic int act_code(input int i);
    case (i)
      0: return int'(code_a);
      1: return int'(code_b);
      2: return int'(code_c);
      default: return int'(code_d);
    endcase
  endfunction

  function automatic int act_tick(input int i);
    case (i)
      0: return int'(tick_a);
      1: return int'(tick_b);
      2: return int'(tick_c);
      default: return int'(tick_d);
    endcase
  endfunction

  function automatic int act_wrap(input int i);
    case (i)
      0: return int'(wrap_a);
      1: return int'(wrap_b);
      2: return int'(wrap_c);
      default: return int'(wrap_d);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; load = 1'b0; load_code = 2'd0;
    step();
    reset = 1'b0;
  endtask

  vec_t vecs[$];
  int   n;

  initial begin
    w_of = '{2, 2, 1, 1};
    d_of = '{4, 3, 4, 1};

    // Reset state
    step();
    check("reset_code_a", int'(code_a), 0);
    check("reset_tick_a", int'(tick_a), 0);
    check("reset_wrap_a", int'(wrap_a), 0);
    reset = 1'b0;

    // Reset mid-slot on CODE_W=2, DWELL=4
    enable = 1'b1;
    for (int k = 0; k < 6; k++) step();
    check("pre_reset_code_a", int'(code_a), 1);
    #3 reset = 1'b1;
    #1;
    check("async_reset_code_a", int'(code_a), 0);
    check("async_reset_tick_a", int'(tick_a), 0);
    check("async_reset_wrap_a", int'(wrap_a), 0);
    step();
    reset = 1'b0;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (tick_a) begin
        n = k;
        break;
      end
    end
    check("first_tick_edges_a", n, 4);
    check("first_tick_code_a", int'(code_a), 1);

    // Table vectors on CODE_W=2, DWELL=3: steady scan, load priority, reload of same code
    do_reset();
    vecs.push_back('{1, 0, 0, 0, 0, 0}); vecs.push_back('{1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 1, 0}); vecs.push_back('{1, 0, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 0, 0}); vecs.push_back('{1, 0, 0, 2, 1, 0});
    vecs.push_back('{1, 0, 0, 2, 0, 0}); vecs.push_back('{1, 0, 0, 2, 0, 0});
    vecs.push_back('{1, 0, 0, 3, 1, 0}); vecs.push_back('{1, 0, 0, 3, 0, 0});
    vecs.push_back('{1, 0, 0, 3, 0, 0}); vecs.push_back('{1, 0, 0, 0, 1, 1});
    vecs.push_back('{1, 1, 3, 3, 1, 0}); vecs.push_back('{1, 0, 0, 3, 0, 0});
    vecs.push_back('{1, 0, 0, 3, 0, 0}); vecs.push_back('{1, 1, 2, 2, 1, 0});
    vecs.push_back('{1, 0, 0, 2, 0, 0}); vecs.push_back('{1, 0, 0, 2, 0, 0});
    vecs.push_back('{1, 0, 0, 3, 1, 0}); vecs.push_back('{1, 0, 0, 3, 0, 0});
    vecs.push_back('{1, 0, 0, 3, 0, 0}); vecs.push_back('{1, 0, 0, 0, 1, 1});
    vecs.push_back('{0, 1, 0, 0, 1, 0}); vecs.push_back('{0, 0, 0, 0, 0, 0});
    foreach (vecs[i]) begin
      enable = vecs[i].en; load = vecs[i].ld; load_code = vecs[i].lc;
      step();
      check($sformatf("vec%0d_code", i), int'(code_b), int'(vecs[i].code));
      check($sformatf("vec%0d_tick", i), int'(tick_b), int'(vecs[i].tick));
      check($sformatf("vec%0d_wrap", i), int'(wrap_b), int'(vecs[i].wrap));
    end
    load = 1'b0;

    // Freeze on CODE_W=1, DWELL=4
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("freeze_pre_code_c", int'(code_c), 0);
    end
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("freeze_tick_c", int'(tick_c), 0);
      check("freeze_code_c", int'(code_c), 0);
    end
    enable = 1'b1;
    step();
    check("resume1_code_c", int'(code_c), 0);
    step();
    check("resume2_code_c", int'(code_c), 1);
    check("resume2_tick_c", int'(tick_c), 1);

    // Decoder chain: one-hot alternates every DWELL cycles
    for (int k = 1; k <= 16; k++) begin
      logic [1:0] onehot;
      int         ec;
      step();
      onehot = {code_c == 1'b1, code_c == 1'b0};
      ec = (1 + k / 4) % 2;
      check($sformatf("decoder_k%0d", k), int'(onehot), (ec == 1) ? 2 : 1);
    end

    // DWELL=1, CODE_W=1: code toggles each enabled edge, tick stays high
    do_reset();
    enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("d1_code_k%0d", k), int'(code_d), k % 2);
      check($sformatf("d1_tick_k%0d", k), int'(tick_d), 1);
      check($sformatf("d1_wrap_k%0d", k), int'(wrap_d), (k % 2 == 0) ? 1 : 0);
    end

    // Randomized run against the reference model
    do_reset();
    model_edge(1'b1, 1'b0, 1'b0, 2'd0);
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic r, e, l;
      logic [1:0] lc;
      r  = ($urandom_range(0, 39) == 0);
      e  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 7) == 0);
      lc = 2'($urandom_range(0, 3));
      reset = r; enable = e; load = l; load_code = lc;
      step();
      model_edge(r, e, l, lc);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("rnd%0d_code_u%0d", cyc, i), act_code(i), exp_code(i));
        check($sformatf("rnd%0d_tick_u%0d", cyc, i), act_tick(i), et[i]);
        check($sformatf("rnd%0d_wrap_u%0d", cyc, i), act_wrap(i), ew[i]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
